// File: rtl/nesoi_video_pkg.sv
`timescale 1ns/1ps
// nesoi_video_pkg: mode presets, colour-bar constants and timing helpers
// shared by the raster timing generator.
package nesoi_video_pkg;

  // 640x480@60, 25.175 MHz nominal pixel clock (run at 25 MHz)
  localparam int   VGA640_H_ACTIVE = 640;
  localparam int   VGA640_H_FP     = 16;
  localparam int   VGA640_H_SYNC   = 96;
  localparam int   VGA640_H_BP     = 48;
  localparam int   VGA640_V_ACTIVE = 480;
  localparam int   VGA640_V_FP     = 10;
  localparam int   VGA640_V_SYNC   = 2;
  localparam int   VGA640_V_BP     = 33;
  localparam logic VGA640_H_POL    = 1'b0;
  localparam logic VGA640_V_POL    = 1'b0;

  // 1280x720@60, 74.25 MHz pixel clock
  localparam int   HD720_H_ACTIVE = 1280;
  localparam int   HD720_H_FP     = 110;
  localparam int   HD720_H_SYNC   = 40;
  localparam int   HD720_H_BP     = 220;
  localparam int   HD720_V_ACTIVE = 720;
  localparam int   HD720_V_FP     = 5;
  localparam int   HD720_V_SYNC   = 5;
  localparam int   HD720_V_BP     = 20;
  localparam logic HD720_H_POL    = 1'b1;
  localparam logic HD720_V_POL    = 1'b1;

  // Colour bars, left to right
  localparam int          NUM_BARS    = 8;
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/raster_counter.sv
`timescale 1ns/1ps
// raster_counter: modulo-TOTAL counter that advances on inc and flags the
// cycle on which it rolls over, so counters can be chained.
module raster_counter #(
  parameter int TOTAL = 800,
  parameter int CW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap
);

  assign wrap = inc && (count == CW'(TOTAL - 1));

  // Count up on inc, returning to zero after TOTAL-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc)
      count <= wrap ? '0 : count + CW'(1);
  end

endmodule

// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// video_timing_gen: parametrised raster timing generator (hsync, vsync, de,
// pixel coordinates, line/frame strobes). All outputs are registered one
// cycle behind the internal counters. Define TEST_PATTERN_EN to add the
// 24-bit colour-bar output rgb.
module video_timing_gen
  import nesoi_video_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic H_POL    = VGA640_H_POL,
  parameter logic V_POL    = VGA640_V_POL,
  parameter int   CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef TEST_PATTERN_EN
  ,
  output logic [23:0]   rgb
`endif
);

  localparam int H_TOTAL      = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL      = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_timing
    $error("video_timing_gen: every active/porch/sync parameter must be non-zero");
  end

  if ((H_TOTAL >> CW) != 0 || (V_TOTAL >> CW) != 0) begin : g_bad_cw
    $error("video_timing_gen: CW too small to hold H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          h_wrap;
  logic          v_wrap;
  logic          frame_top;
  logic          de_next;
  logic          hsync_next;
  logic          vsync_next;
  logic          line_next;

  raster_counter #(.TOTAL(H_TOTAL), .CW(CW)) u_h_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (en),
    .count (h_count),
    .wrap  (h_wrap)
  );

  raster_counter #(.TOTAL(V_TOTAL), .CW(CW)) u_v_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (h_wrap),
    .count (v_count),
    .wrap  (v_wrap)
  );

  // Remembers whether the vertical counter sits on line 0, derived from the wrap strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_top <= 1'b1;
    else if (v_wrap)
      frame_top <= 1'b1;
    else if (h_wrap)
      frame_top <= 1'b0;
  end

  // Decode regions from the current counter position
  always_comb begin
    de_next    = (h_count < CW'(H_ACTIVE)) && (v_count < CW'(V_ACTIVE));
    hsync_next = ((h_count >= CW'(H_SYNC_START)) && (h_count < CW'(H_SYNC_END))) ? H_POL : ~H_POL;
    vsync_next = ((v_count >= CW'(V_SYNC_START)) && (v_count < CW'(V_SYNC_END))) ? V_POL : ~V_POL;
    line_next  = (h_count == '0);
  end

  // Output register: follows the counters while enabled, holds (strobes cleared) while frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      de          <= de_next;
      x           <= h_count;
      y           <= v_count;
      line_start  <= line_next;
      frame_start <= line_next && frame_top;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / NUM_BARS;

  // The last bar takes every column from 7*BAR_W onward, absorbing the remainder
  function automatic logic [2:0] bar_of(input logic [CW-1:0] h);
    logic [2:0] idx;
    idx = '0;
    for (int i = 1; i < NUM_BARS; i++)
      if (BAR_W > 0 && h >= CW'(i * BAR_W))
        idx = 3'(i);
    return idx;
  endfunction

  logic [23:0] rgb_next;

  // Colour of the current column, blanked outside the active area
  always_comb begin
    rgb_next = de_next ? bar_colour(bar_of(h_count)) : 24'h000000;
  end

  // Pattern register, aligned with de
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rgb <= 24'h000000;
    else if (en)
      rgb <= rgb_next;
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// tb_video_timing_gen: scoreboard bench with two generator instances, a small
// active-low mode (25x11 total) and a tiny active-high mode (7x5 total).
module tb_video_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  logic        hsync_a, vsync_a, de_a, line_start_a, frame_start_a;
  logic [11:0] x_a, y_a;
  logic        hsync_b, vsync_b, de_b, line_start_b, frame_start_b;
  logic [11:0] x_b, y_b;
`ifdef TEST_PATTERN_EN
  logic [23:0] rgb_a, rgb_b;
`endif

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0),  .V_POL(1'b0), .CW(12)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(line_start_a), .frame_start(frame_start_a)
`ifdef TEST_PATTERN_EN
    , .rgb(rgb_a)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(12)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(line_start_b), .frame_start(frame_start_b)
`ifdef TEST_PATTERN_EN
    , .rgb(rgb_b)
`endif
  );

  always #5 clk = ~clk;

  // Mode tables: index 0 = dut_a, 1 = dut_b
  int   ha[2]   = '{16, 4};
  int   hf[2]   = '{2, 1};
  int   hsw[2]  = '{3, 1};
  int   va[2]   = '{6, 2};
  int   vf[2]   = '{1, 1};
  int   vsw[2]  = '{2, 1};
  int   htot[2] = '{25, 7};
  int   vtot[2] = '{11, 5};
  logic hp[2]   = '{1'b0, 1'b1};
  logic vp[2]   = '{1'b0, 1'b1};

  int   errors = 0;
  int   checks = 0;
  int   mh[2];
  int   mv[2];
  obs_t last_exp[2];
  obs_t qa[$];
  obs_t qb[$];
  obs_t oa, ob;

  function automatic obs_t reset_obs(input int d);
    obs_t r;
    r    = '0;
    r.hs = ~hp[d];
    r.vs = ~vp[d];
    return r;
  endfunction

  function automatic obs_t expect_at(input int d, input int h, input int v);
    obs_t r;
    r.x  = 12'(h);
    r.y  = 12'(v);
    r.de = (h < ha[d]) && (v < va[d]);
    r.hs = (h >= ha[d] + hf[d] && h < ha[d] + hf[d] + hsw[d]) ? hp[d] : ~hp[d];
    r.vs = (v >= va[d] + vf[d] && v < va[d] + vf[d] + vsw[d]) ? vp[d] : ~vp[d];
    r.ls = (h == 0);
    r.fs = (h == 0) && (v == 0);
    return r;
  endfunction

  function automatic obs_t sample_a();
    return {hsync_a, vsync_a, de_a, line_start_a, frame_start_a, x_a, y_a};
  endfunction

  function automatic obs_t sample_b();
    return {hsync_b, vsync_b, de_b, line_start_b, frame_start_b, x_b, y_b};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mh[d]       = 0;
      mv[d]       = 0;
      last_exp[d] = reset_obs(d);
    end
    qa.delete();
    qb.delete();
  endtask

  // One clock: push expectations for the current en, clock, pop and compare
  task automatic cycle();
    obs_t e;
    for (int d = 0; d < 2; d++) begin
      if (en) begin
        e = expect_at(d, mh[d], mv[d]);
        if (mh[d] == htot[d] - 1) begin
          mh[d] = 0;
          mv[d] = (mv[d] == vtot[d] - 1) ? 0 : mv[d] + 1;
        end else begin
          mh[d] = mh[d] + 1;
        end
      end else begin
        e    = last_exp[d];
        e.ls = 1'b0;
        e.fs = 1'b0;
      end
      last_exp[d] = e;
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    @(posedge clk);
    #1;
    oa = sample_a();
    ob = sample_b();
    e = qa.pop_front();
    checks++;
    if (oa !== e) begin
      errors++;
      $display("FAIL scoreboard_a: got %h expected %h", oa, e);
    end
    e = qb.pop_front();
    checks++;
    if (ob !== e) begin
      errors++;
      $display("FAIL scoreboard_b: got %h expected %h", ob, e);
    end
  endtask

  task automatic align_frame_a(input string tag);
    for (int i = 0; i < 400 && oa.fs !== 1'b1; i++) cycle();
    checks++;
    if (oa.fs !== 1'b1) begin
      errors++;
      $display("FAIL %s: frame_start_a not seen, got %b required 1", tag, oa.fs);
    end
  endtask

  task automatic test_reset();
    obs_t ra, rb;
    en = 1'b1;
    #1 rst = 1'b1;
    #1;
    ra = sample_a();
    rb = sample_b();
    checks++;
    if (ra !== reset_obs(0)) begin
      errors++;
      $display("FAIL reset_a: got %h required %h", ra, reset_obs(0));
    end
    checks++;
    if (rb !== reset_obs(1)) begin
      errors++;
      $display("FAIL reset_b: got %h required %h", rb, reset_obs(1));
    end
`ifdef TEST_PATTERN_EN
    checks++;
    if (rgb_a !== 24'h0) begin
      errors++;
      $display("FAIL reset_rgb: got %h required 000000", rgb_a);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle();
    checks++;
    if (oa.fs !== 1'b1 || oa.ls !== 1'b1 || oa.de !== 1'b1 || oa.x !== 12'd0 || oa.y !== 12'd0) begin
      errors++;
      $display("FAIL first_edge: got fs=%b ls=%b de=%b x=%0d y=%0d required 1 1 1 0 0",
               oa.fs, oa.ls, oa.de, oa.x, oa.y);
    end
  endtask

  task automatic test_frames_a();
    align_frame_a("align_frames");
    for (int f = 0; f < 2; f++) begin
      int period = 0, de_n = 0, hs_n = 0, vs_n = 0;
      int hs_min = 9999, hs_max = -1, vs_min = 9999, vs_max = -1;
      do begin
        if (oa.de) de_n++;
        if (oa.hs == 1'b0) begin
          hs_n++;
          if (int'(oa.x) < hs_min) hs_min = int'(oa.x);
          if (int'(oa.x) > hs_max) hs_max = int'(oa.x);
        end
        if (oa.vs == 1'b0) begin
          vs_n++;
          if (int'(oa.y) < vs_min) vs_min = int'(oa.y);
          if (int'(oa.y) > vs_max) vs_max = int'(oa.y);
        end
        cycle();
        period++;
      end while (oa.fs !== 1'b1 && period < 400);
      checks++; if (period != 275) begin errors++; $display("FAIL frame_period_a: got %0d required 275", period); end
      checks++; if (de_n != 96)    begin errors++; $display("FAIL de_count_a: got %0d required 96", de_n); end
      checks++; if (hs_n != 33)    begin errors++; $display("FAIL hsync_count_a: got %0d required 33", hs_n); end
      checks++; if (hs_min != 18)  begin errors++; $display("FAIL hsync_first_x: got %0d required 18", hs_min); end
      checks++; if (hs_max != 20)  begin errors++; $display("FAIL hsync_last_x: got %0d required 20", hs_max); end
      checks++; if (vs_n != 50)    begin errors++; $display("FAIL vsync_count_a: got %0d required 50", vs_n); end
      checks++; if (vs_min != 7)   begin errors++; $display("FAIL vsync_first_y: got %0d required 7", vs_min); end
      checks++; if (vs_max != 8)   begin errors++; $display("FAIL vsync_last_y: got %0d required 8", vs_max); end
    end
  endtask

  task automatic test_tiny_b();
    int period = 0, de_n = 0, hs_n = 0, hs_bad = 0, vs_n = 0;
    for (int i = 0; i < 100 && ob.fs !== 1'b1; i++) cycle();
    checks++;
    if (ob.fs !== 1'b1) begin
      errors++;
      $display("FAIL align_b: frame_start_b not seen, got %b required 1", ob.fs);
    end
    do begin
      if (ob.de) de_n++;
      if (ob.hs == 1'b1) begin
        hs_n++;
        if (ob.x != 12'd5) hs_bad++;
      end
      if (ob.vs == 1'b1) vs_n++;
      cycle();
      period++;
    end while (ob.fs !== 1'b1 && period < 100);
    checks++; if (period != 35) begin errors++; $display("FAIL frame_period_b: got %0d required 35", period); end
    checks++; if (de_n != 8)    begin errors++; $display("FAIL de_count_b: got %0d required 8", de_n); end
    checks++; if (hs_n != 5)    begin errors++; $display("FAIL hsync_count_b: got %0d required 5", hs_n); end
    checks++; if (hs_bad != 0)  begin errors++; $display("FAIL hsync_x_b: got %0d off-column pulses required 0", hs_bad); end
    checks++; if (vs_n != 7)    begin errors++; $display("FAIL vsync_count_b: got %0d required 7", vs_n); end
  endtask

  task automatic test_en_hold();
    int c = 0;
    align_frame_a("align_hold");
    for (int i = 0; i < 400 && !(oa.x == 12'd10 && oa.y == 12'd3); i++) begin
      cycle();
      c++;
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      c++;
      checks++;
      if (oa.x !== 12'd10 || oa.y !== 12'd3 || oa.ls !== 1'b0 || oa.fs !== 1'b0) begin
        errors++;
        $display("FAIL hold: got x=%0d y=%0d ls=%b fs=%b required 10 3 0 0", oa.x, oa.y, oa.ls, oa.fs);
      end
    end
    en = 1'b1;
    cycle();
    c++;
    checks++;
    if (oa.x !== 12'd11 || oa.y !== 12'd3 || oa.ls !== 1'b0) begin
      errors++;
      $display("FAIL resume: got x=%0d y=%0d ls=%b required 11 3 0", oa.x, oa.y, oa.ls);
    end
    for (int i = 0; i < 600 && oa.fs !== 1'b1; i++) begin
      cycle();
      c++;
    end
    checks++;
    if (c != 285) begin
      errors++;
      $display("FAIL stretched_period: got %0d required 285", c);
    end
  endtask

  task automatic test_async_reset();
    obs_t ra, rb;
    for (int i = 0; i < 400 && !(oa.x == 12'd10 && oa.y == 12'd4); i++) cycle();
    #3 rst = 1'b1;
    #1;
    ra = sample_a();
    rb = sample_b();
    checks++;
    if (ra !== reset_obs(0)) begin
      errors++;
      $display("FAIL async_reset_a: got %h required %h", ra, reset_obs(0));
    end
    checks++;
    if (rb !== reset_obs(1)) begin
      errors++;
      $display("FAIL async_reset_b: got %h required %h", rb, reset_obs(1));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle();
    checks++;
    if (oa.fs !== 1'b1 || oa.x !== 12'd0 || oa.y !== 12'd0) begin
      errors++;
      $display("FAIL restart: got fs=%b x=%0d y=%0d required 1 0 0", oa.fs, oa.x, oa.y);
    end
    for (int i = 0; i < 60; i++) cycle();
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    logic [23:0] bars [8];
    logic [23:0] want;
    int          idx;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    align_frame_a("align_pattern");
    for (int i = 0; i < 25; i++) begin
      idx  = int'(oa.x) / 2;
      if (idx > 7) idx = 7;
      want = (oa.x < 12'd16) ? bars[idx] : 24'h000000;
      checks++;
      if (rgb_a !== want) begin
        errors++;
        $display("FAIL rgb_x%0d: got %h required %h", oa.x, rgb_a, want);
      end
      cycle();
    end
  endtask
`endif

  initial begin
    oa = '0;
    ob = '0;
    model_reset();
    test_reset();
    test_frames_a();
    test_tiny_b();
    test_en_hold();
    test_async_reset();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
